lsu_mem_master: RTL and testbench

//  Initiator side of the single-port sram ren/wen/wmask/valid protocol. Accepts one

---
 rtl/lsu_mem_master.sv | 160 ++++++++++++++++
 tb/tb_lsu_mem_master.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// LSU-side initiator for the single-port sram ren/wen/wmask/valid protocol.
// One load/store in flight, byte-lane alignment, misalign and timeout errors.
module lsu_mem_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [7:0]  mem_wmask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       off_q;
    logic [1:0]       size_q;
    logic             wen_q;
    logic             uns_q;

    logic             misaligned;
    logic [3:0]       base_mask;
    logic [3:0]       lane_mask;
    logic [31:0]      lane_wdata;
    logic [31:0]      shifted;
    logic [31:0]      load_ext;

    // Decode alignment and byte-lane placement of the incoming request
    always_comb begin
        misaligned = 1'b0;
        base_mask  = 4'b0000;
        case (req_size)
            2'd0: base_mask = 4'b0001;
            2'd1: begin
                base_mask  = 4'b0011;
                misaligned = req_addr[0];
            end
            2'd2: begin
                base_mask  = 4'b1111;
                misaligned = |req_addr[1:0];
            end
            default: misaligned = 1'b1;
        endcase
        lane_mask  = base_mask << req_addr[1:0];
        lane_wdata = req_wdata << {req_addr[1:0], 3'b000};
    end

    // Right-justify returned sram word and extend to the access size
    always_comb begin
        shifted  = mem_rdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (size_q)
            2'd0: load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'd1: load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Request FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            off_q      <= 2'd0;
            size_q     <= 2'd0;
            wen_q      <= 1'b0;
            uns_q      <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_wmask  <= 8'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        off_q     <= req_addr[1:0];
                        size_q    <= req_size;
                        wen_q     <= req_wen;
                        uns_q     <= req_unsigned;
                        req_ready <= 1'b0;
                        if (misaligned) begin
                            state      <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state     <= S_ISSUE;
                            mem_ren   <= ~req_wen;
                            mem_wen   <= req_wen;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wmask <= {4'b0000, lane_mask};
                            mem_wdata <= lane_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    mem_ren <= 1'b0;
                    mem_wen <= 1'b0;
                    cnt     <= '0;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_valid) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= wen_q ? 32'd0 : load_ext;
                    end else if (cnt == CNT_LAST) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= 32'd0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        resp_rdata <= 32'd0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Randomized bench for lsu_mem_master with a behavioural
// sram responder and byte-lane reference model.
module tb_lsu_mem_master;

    localparam int TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [7:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_valid;

    int checks = 0;
    int failures = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    lsu_mem_master #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_wen(req_wen),
        .req_size(req_size),
        .req_unsigned(req_unsigned),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_ren(mem_ren),
        .mem_wen(mem_wen),
        .mem_wmask(mem_wmask),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_valid(mem_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] word,
                                               input int off, input int size,
                                               input bit uns);
        longint unsigned v;
        v = word;
        v = v >> (8 * off);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 64'hFFFF_0000;
        end
        return v[31:0];
    endfunction

    // lat: WAIT cycle index of mem_valid (0 = never), hold: cycles resp_ready low
    task automatic run_req(input logic wen, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int lat, input int hold, input bit stray);
        bit          bad;
        int          off;
        int          got_at;
        logic [31:0] exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        off = int'(addr % 4);
        bad = (size == 3) || (size == 1 && off % 2 != 0) ||
              (size == 2 && off != 0);
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", req_ready, 0);
        if (bad) begin
            chk("mis_no_access", {mem_ren, mem_wen}, 0);
            chk("mis_resp_valid", resp_valid, 1);
            exp_err   = 1'b1;
            exp_rdata = 32'd0;
        end else begin
            exp_mask  = ((1 << (1 << size)) - 1) << off;
            exp_wdata = wdata << (8 * off);
            chk("pulse_ren", mem_ren, !wen);
            chk("pulse_wen", mem_wen, wen);
            chk("mem_addr", mem_addr, addr - off);
            chk("mem_wmask", mem_wmask, exp_mask);
            if (wen) chk("mem_wdata", mem_wdata, exp_wdata);
            got_at = 0;
            for (int k = 0; k < TO + 10; k++) begin
                if (k == lat || (stray && k == 0)) begin
                    mem_valid = 1'b1;
                    mem_rdata = (k == lat) ? rword : ~rword;
                end
                @(negedge clk);
                mem_valid = 1'b0;
                if (k == 0) chk("pulse_one_cycle", {mem_ren, mem_wen}, 0);
                if (resp_valid) begin
                    got_at = k + 1;
                    break;
                end
            end
            chk("resp_latency", got_at, lat > 0 ? lat + 1 : TO + 1);
            exp_err   = (lat == 0);
            exp_rdata = (wen || lat == 0) ? 32'd0 :
                        model_load(rword, off, size, uns);
        end
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, exp_err);
        chk("resp_rdata", resp_rdata, exp_rdata);
        last_rdata = resp_rdata;
        last_err   = resp_err;
        for (int h = 0; h < hold; h++) begin
            if ($urandom_range(0, 1) == 1) begin
                mem_valid = 1'b1;
                mem_rdata = $urandom;
            end
            @(negedge clk);
            mem_valid = 1'b0;
            chk("hold_valid", resp_valid, 1);
            chk("hold_err", resp_err, exp_err);
            chk("hold_rdata", resp_rdata, exp_rdata);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_done", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_wen      = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        resp_ready   = 1'b0;
        mem_rdata    = 32'd0;
        mem_valid    = 1'b0;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_ctl", {mem_ren, mem_wen, mem_wmask}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_req(0, 2, 0, 32'h8000_0004, 0, 32'hDEAD_BEEF, 1, 0, 0);
        chk("t1_rdata", last_rdata, 32'hDEAD_BEEF);
        run_req(0, 0, 0, 32'h8000_0003, 0, 32'h8012_3456, 2, 1, 0);
        chk("t2_signed", last_rdata, 32'hFFFF_FF80);
        run_req(0, 0, 1, 32'h8000_0003, 0, 32'h8012_3456, 1, 0, 1);
        chk("t2_unsigned", last_rdata, 32'h0000_0080);
        run_req(1, 1, 0, 32'h8000_0002, 32'h0000_ABCD, 32'h1234_5678, 3, 0, 0);
        chk("t3_store_rdata", last_rdata, 0);
        run_req(0, 2, 0, 32'h8000_0001, 0, 0, 1, 0, 0);
        chk("t4_mis_err", last_err, 1);
        run_req(0, 2, 0, 32'h8000_0008, 0, 32'h5555_AAAA, 0, 5, 1);
        chk("t5_timeout_err", last_err, 1);

        for (int i = 0; i < 80; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'h8000_0000 | ($urandom & 32'h0000_0FFF);
            run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    a, $urandom, $urandom, $urandom_range(1, 6),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h8000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_resp_valid", resp_valid, 0);
        chk("arst_mem_ctl", {mem_ren, mem_wen, mem_wmask}, 0);
        chk("arst_mem_addr", mem_addr, 0);
        @(negedge clk);
        rst       = 1'b0;
        mem_valid = 1'b1;
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("arst_no_resp", resp_valid, 0);
            chk("arst_idle", req_ready, 1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
